// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Define VEDIC_SIGNED_EN to add the sgn port and two's-complement operand support.
module vedic_mult_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int H = WIDTH / 2;
  localparam int D = H / 2;

  function automatic logic [3:0] cell2x2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, c1;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
  endfunction

  // Quadrant product: 2-bit digit cells summed column by column (vertically and crosswise).
  function automatic logic [2*H-1:0] quadMul(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [2*H-1:0] acc;
    logic [2*H-1:0] col;
    acc = '0;
    for (int k = 0; k < 2*D-1; k++) begin
      col = '0;
      for (int i = 0; i < D; i++) begin
        for (int j = 0; j < D; j++) begin
          if (i + j == k) begin
            col = col + {{(2*H-4){1'b0}}, cell2x2(x[2*i +: 2], y[2*j +: 2])};
          end
        end
      end
      acc = acc + (col << (2*k));
    end
    return acc;
  endfunction

  logic               v1Q, v2Q, v3Q, v4Q;
  logic               v1D, v2D, v3D, v4D;
  logic [WIDTH-1:0]   aQ, bQ, aD, bD;
  logic [2*H-1:0]     q0Q, q1Q, q2Q, q3Q;
  logic [2*H-1:0]     q0D, q1D, q2D, q3D;
  logic [2*H+1:0]     midQ, midD;
  logic [H-1:0]       loQ, loD;
  logic [2*H-1:0]     hiQ, hiD;
  logic [2*WIDTH-1:0] pQ, pD;
  logic [3*H-1:0]     upper;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   aMag, bMag;
  logic               inFire, adv1, adv2, adv3, outFire;

  // Each stage moves when the one below is empty or moving, so bubbles collapse under a stall.
  assign outFire  = v4Q && out_ready;
  assign adv3     = v3Q && (!v4Q || out_ready);
  assign adv2     = v2Q && (!v3Q || adv3);
  assign adv1     = v1Q && (!v2Q || adv2);
  assign in_ready = !rst && (!v1Q || adv1);
  assign inFire   = in_valid && in_ready;

  assign upper = {{(H-2){1'b0}}, midQ} + {hiQ, {H{1'b0}}};

`ifdef VEDIC_SIGNED_EN
  logic s1Q, s2Q, s3Q, s1D, s2D, s3D;

  assign aMag = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign bMag = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign prod = s3Q ? (~{upper, loQ} + (2*WIDTH)'(1)) : {upper, loQ};

  always_comb begin
    s1D = s1Q;
    s2D = s2Q;
    s3D = s3Q;
    if (inFire) s1D = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    if (adv1)   s2D = s1Q;
    if (adv2)   s3D = s2Q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Q <= 1'b0;
      s2Q <= 1'b0;
      s3Q <= 1'b0;
    end else begin
      s1Q <= s1D;
      s2Q <= s2D;
      s3Q <= s3D;
    end
  end
`else
  assign aMag = a;
  assign bMag = b;
  assign prod = {upper, loQ};
`endif

  always_comb begin
    v1D  = inFire || (v1Q && !adv1);
    v2D  = adv1   || (v2Q && !adv2);
    v3D  = adv2   || (v3Q && !adv3);
    v4D  = adv3   || (v4Q && !outFire);
    aD   = aQ;
    bD   = bQ;
    q0D  = q0Q;
    q1D  = q1Q;
    q2D  = q2Q;
    q3D  = q3Q;
    midD = midQ;
    loD  = loQ;
    hiD  = hiQ;
    pD   = pQ;
    if (inFire) begin
      aD = aMag;
      bD = bMag;
    end
    if (adv1) begin
      q0D = quadMul(aQ[H-1:0],     bQ[H-1:0]);
      q1D = quadMul(aQ[WIDTH-1:H], bQ[H-1:0]);
      q2D = quadMul(aQ[H-1:0],     bQ[WIDTH-1:H]);
      q3D = quadMul(aQ[WIDTH-1:H], bQ[WIDTH-1:H]);
    end
    if (adv2) begin
      midD = {2'b00, q1Q} + {2'b00, q2Q} + {{(H+2){1'b0}}, q0Q[2*H-1:H]};
      loD  = q0Q[H-1:0];
      hiD  = q3Q;
    end
    if (adv3) pD = prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1Q  <= 1'b0;
      v2Q  <= 1'b0;
      v3Q  <= 1'b0;
      v4Q  <= 1'b0;
      aQ   <= '0;
      bQ   <= '0;
      q0Q  <= '0;
      q1Q  <= '0;
      q2Q  <= '0;
      q3Q  <= '0;
      midQ <= '0;
      loQ  <= '0;
      hiQ  <= '0;
      pQ   <= '0;
    end else begin
      v1Q  <= v1D;
      v2Q  <= v2D;
      v3Q  <= v3D;
      v4Q  <= v4D;
      aQ   <= aD;
      bQ   <= bD;
      q0Q  <= q0D;
      q1Q  <= q1D;
      q2Q  <= q2D;
      q3Q  <= q3D;
      midQ <= midD;
      loQ  <= loD;
      hiQ  <= hiD;
      pQ   <= pD;
    end
  end

  assign out_valid = v4Q;
  assign p         = pQ;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe: directed tables, handshake corner sequences and a
// randomized stream scored against a plain-arithmetic product model.
module tb_vedic_mult_pipe;

  localparam int W = 16;
`ifdef VEDIC_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] e;
  } vec16_t;

  typedef struct {
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] e8;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [63:0] e32;
  } corner_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           inValid, inReady, outValid, outReady;
  logic [W-1:0]   aIn, bIn;
  logic           sgnIn;
  logic [2*W-1:0] pOut;

  logic           v8, r8, ov8;
  logic [7:0]     a8, b8;
  logic [15:0]    p8;
  logic           v32, r32, ov32;
  logic [31:0]    a32, b32;
  logic [63:0]    p32;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int accepts = 0;
  int fires = 0;
  int firstFire = -1;
  int lastFire = -1;
  logic lastInReady;
  logic [31:0] expQ[$];

  vedic_mult_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .a(aIn), .b(bIn),
`ifdef VEDIC_SIGNED_EN
    .sgn(sgnIn),
`endif
    .out_valid(outValid), .out_ready(outReady), .p(pOut)
  );

  vedic_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
`ifdef VEDIC_SIGNED_EN
    .sgn(1'b0),
`endif
    .out_valid(ov8), .out_ready(1'b1), .p(p8)
  );

  vedic_mult_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
`ifdef VEDIC_SIGNED_EN
    .sgn(1'b0),
`endif
    .out_valid(ov32), .out_ready(1'b1), .p(p32)
  );

  function automatic logic [31:0] refProd(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic signed [31:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    if (s && SIGNED_EN) return sx * sy;
    return {16'b0, x} * {16'b0, y};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive at the negedge, score both handshakes, advance to the next negedge.
  task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                               input logic s, input logic ordy);
    inValid  = v;
    aIn      = av;
    bIn      = bv;
    sgnIn    = s;
    outReady = ordy;
    #1;
    lastInReady = inReady;
    if (!rst && inValid && inReady) begin
      expQ.push_back(refProd(av, bv, s));
      accepts++;
    end
    if (!rst && outValid && outReady) begin
      fires++;
      if (firstFire < 0) firstFire = cycle;
      lastFire = cycle;
      if (expQ.size() == 0) checkOutput("spurious_out_valid", outValid, 0);
      else checkOutput("stream_p", pOut, expQ.pop_front());
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 30) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("drain_empty", expQ.size(), 0);
    checkOutput("idle_out_valid", outValid, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec16_t  tab16[$];
    corner_t tabC[$];
    int      lat;
    logic    s;

    tab16.push_back('{16'h0000, 16'h1234, 1'b0, 32'h0000_0000});
    tab16.push_back('{16'h0001, 16'hBEEF, 1'b0, 32'h0000_BEEF});
    tab16.push_back('{16'h8000, 16'h8000, 1'b0, 32'h4000_0000});
    tab16.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
    tab16.push_back('{16'h00FF, 16'h0100, 1'b0, 32'h0000_FF00});
    tab16.push_back('{16'h1234, 16'h5678, 1'b0, 32'h0626_0060});
    tab16.push_back('{16'hFFFD, 16'h0005, 1'b0, 32'h0004_FFF1});
`ifdef VEDIC_SIGNED_EN
    tab16.push_back('{16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1});
    tab16.push_back('{16'h8000, 16'h8000, 1'b1, 32'h4000_0000});
    tab16.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000});
    tab16.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001});
`endif

    tabC.push_back('{8'h00, 8'hA5, 16'h0000, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0});
    tabC.push_back('{8'h01, 8'hA5, 16'h00A5, 32'h0000_0001, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF});
    tabC.push_back('{8'h80, 8'h80, 16'h4000, 32'h0000_0080, 32'h0000_0080, 64'h0000_0000_0000_4000});
    tabC.push_back('{8'hFF, 8'hFF, 16'hFE01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
    tabC.push_back('{8'h0F, 8'h11, 16'h00FF, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});

    rst = 1'b1; inValid = 1'b0; aIn = '0; bIn = '0; sgnIn = 1'b0; outReady = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; v32 = 1'b0; a32 = '0; b32 = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("in_ready_in_reset", inReady, 0);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_p", pOut, 0);
    checkOutput("reset_in_ready", inReady, 1);

    $display("[TB] latency of a single all-ones product");
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    lat = 1;
    while (!outValid && lat < 12) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      lat++;
    end
    checkOutput("latency_cycles", lat, 4);
    checkOutput("latency_p", pOut, 32'hFFFE_0001);
    drain();

    $display("[TB] directed 16-bit vectors");
    foreach (tab16[i]) begin
      applyStimulus(1'b1, tab16[i].a, tab16[i].b, tab16[i].s, 1'b1);
      lat = 1;
      while (!outValid && lat < 12) begin
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        lat++;
      end
      checkOutput("table16_p", pOut, {32'h0, tab16[i].e});
      drain();
    end

    $display("[TB] back-to-back stream of 8");
    fires = 0; firstFire = -1; lastFire = -1;
    for (int i = 0; i < 8; i++) begin
      s = SIGNED_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), s, 1'b1);
      checkOutput("b2b_in_ready", lastInReady, 1);
    end
    drain();
    checkOutput("b2b_count", fires, 8);
    checkOutput("b2b_consecutive", lastFire - firstFire, 7);

    $display("[TB] stall with out_ready low for 6 cycles");
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      if (i == 3 || i == 5) begin
        checkOutput("stall_out_valid", outValid, 1);
        checkOutput("stall_p_held", pOut, expQ[0]);
      end
    end
    checkOutput("stall_accepts", accepts, 4);
    checkOutput("stall_in_ready", inReady, 0);
    fires = 0;
    drain();
    checkOutput("stall_drain_count", fires, 4);

    $display("[TB] reset with 3 operations in flight");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
    rst = 1'b1; inValid = 1'b1; aIn = 16'h00FF; bIn = 16'h00FF; outReady = 1'b1;
    #1;
    checkOutput("in_ready_during_rst", inReady, 0);
    @(negedge clk);
    rst = 1'b0; inValid = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_p", pOut, 0);
    checkOutput("post_rst_in_ready", inReady, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("post_rst_no_stale", outValid, 0);
    end

    $display("[TB] 8-bit and 32-bit corners");
    foreach (tabC[i]) begin
      v8 = 1'b1; a8 = tabC[i].a8; b8 = tabC[i].b8;
      v32 = 1'b1; a32 = tabC[i].a32; b32 = tabC[i].b32;
      #1;
      checkOutput("corner_in_ready8", r8, 1);
      checkOutput("corner_in_ready32", r32, 1);
      @(negedge clk);
      v8 = 1'b0; v32 = 1'b0;
      lat = 1;
      while (!(ov8 && ov32) && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      checkOutput("corner_latency", lat, 4);
      checkOutput("w8_p", p8, tabC[i].e8);
      checkOutput("w32_p", p32, tabC[i].e32);
      @(negedge clk);
    end

    $display("[TB] random stream with random backpressure");
    accepts = 0; fires = 0;
    for (int i = 0; i < 80; i++) begin
      s = SIGNED_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), s,
                    ($urandom_range(0, 3) != 0));
    end
    drain();
    checkOutput("random_accept_vs_output", fires, accepts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
